npc_unit: RTL and testbench

NPC_UNIT -- requirements
Module: npc_unit

---
 rtl/npc_unit.sv | 87 ++++++++
 tb/tb_npc_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/npc_unit.sv
// Next-PC unit: selects the next fetch address from the D-stage control
// transfer, keeps the fetch PC register, a sticky misaligned-fetch flag and a
// saturating count of accepted redirects.
module npc_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] d_pc,
  input  logic [2:0]  npc_op,
  input  logic        b_j,
  input  logic [25:0] imm26,
  input  logic [31:0] rs_d,
  output logic [31:0] f_pc,
  output logic [31:0] npc,
  output logic [31:0] d_link,
  output logic        redirect,
  output logic        adel_f,
  output logic [15:0] taken_cnt
);

  // D-stage control transfer encodings; 4-7 are reserved and behave as seq.
  typedef enum logic [2:0] {
    OP_SEQ    = 3'd0,
    OP_BRANCH = 3'd1,
    OP_JUMP   = 3'd2,
    OP_JR     = 3'd3
  } npc_op_e;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  npc_op_e     op;
  logic [31:0] f_pc_plus4;
  logic [31:0] d_pc_plus4;
  logic [31:0] br_offset;
  logic [31:0] br_target;
  logic [31:0] j_target;

  assign op         = npc_op_e'(npc_op);
  assign f_pc_plus4 = f_pc + 32'd4;
  assign d_pc_plus4 = d_pc + 32'd4;
  // Sign-extended imm16 scaled to a word offset; the sum wraps modulo 2^32.
  assign br_offset  = {{14{imm26[15]}}, imm26[15:0], 2'b00};
  assign br_target  = d_pc_plus4 + br_offset;
  assign j_target   = {d_pc_plus4[31:28], imm26, 2'b00};
  assign d_link     = d_pc + 32'd8;

  // Next-PC mux and redirect flag, evaluated every cycle regardless of stall.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    npc      = f_pc_plus4;
    redirect = 1'b0;
    case (op)
      OP_BRANCH: begin
        if (b_j) begin
          npc      = br_target;
          redirect = 1'b1;
        end
      end
      OP_JUMP: begin
        npc      = j_target;
        redirect = 1'b1;
      end
      OP_JR: begin
        npc      = rs_d;
        redirect = 1'b1;
      end
      default: ;
    endcase
  end

  // Fetch PC, sticky misalignment flag and redirect counter; all frozen on stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      f_pc      <= RESET_PC;
      adel_f    <= 1'b0;
      taken_cnt <= '0;
    end else if (!stall) begin
      // A misaligned target is still loaded as-is; the flag reports it downstream.
      f_pc <= npc;
      if (npc[1:0] != 2'b00) adel_f <= 1'b1;
      if (redirect && (taken_cnt != CNT_MAX)) taken_cnt <= taken_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_npc_unit.sv
// Directed self-checking bench for npc_unit.
module tb_npc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] d_pc;
  logic [2:0]  npc_op;
  logic        b_j;
  logic [25:0] imm26;
  logic [31:0] rs_d;
  logic [31:0] f_pc;
  logic [31:0] npc;
  logic [31:0] d_link;
  logic        redirect;
  logic        adel_f;
  logic [15:0] taken_cnt;

  int total = 0;
  int bad   = 0;

  npc_unit dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .d_pc      (d_pc),
    .npc_op    (npc_op),
    .b_j       (b_j),
    .imm26     (imm26),
    .rs_d      (rs_d),
    .f_pc      (f_pc),
    .npc       (npc),
    .d_link    (d_link),
    .redirect  (redirect),
    .adel_f    (adel_f),
    .taken_cnt (taken_cnt)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b0;
    stall  = 1'b0;
    d_pc   = '0;
    npc_op = 3'd0;
    b_j    = 1'b0;
    imm26  = '0;
    rs_d   = '0;

    // Reset takes effect with no clock edge.
    #1 reset = 1'b1;
    #1;
    chk("rst_f_pc", f_pc, 32'h0000_3000);
    chk("rst_adel", {31'd0, adel_f}, 32'd0);
    chk("rst_cnt", {16'd0, taken_cnt}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Sequential fetch.
    chk("seq_npc", npc, 32'h0000_3004);
    chk("seq_redirect", {31'd0, redirect}, 32'd0);
    step();
    chk("seq_f_pc1", f_pc, 32'h0000_3004);
    step();
    chk("seq_f_pc2", f_pc, 32'h0000_3008);
    step();
    chk("seq_f_pc3", f_pc, 32'h0000_300C);
    chk("seq_cnt", {16'd0, taken_cnt}, 32'd0);

    // Backward taken branch: 0x3014 + (-4 << 2) = 0x3004.
    d_pc = 32'h0000_3010; npc_op = 3'd1; b_j = 1'b1; imm26 = 26'h000FFFC;
    #1;
    chk("br_npc", npc, 32'h0000_3004);
    chk("br_redirect", {31'd0, redirect}, 32'd1);
    chk("br_link", d_link, 32'h0000_3018);
    step();
    chk("br_f_pc", f_pc, 32'h0000_3004);
    chk("br_cnt", {16'd0, taken_cnt}, 32'd1);

    // Same branch not taken: falls through to f_pc+4, not counted.
    b_j = 1'b0;
    #1;
    chk("bnt_npc", npc, 32'h0000_3008);
    chk("bnt_redirect", {31'd0, redirect}, 32'd0);
    step();
    chk("bnt_f_pc", f_pc, 32'h0000_3008);
    chk("bnt_cnt", {16'd0, taken_cnt}, 32'd1);

    // Reserved op behaves as sequential.
    npc_op = 3'd6; b_j = 1'b1;
    #1;
    chk("rsv_npc", npc, 32'h0000_300C);
    chk("rsv_redirect", {31'd0, redirect}, 32'd0);

    // Jump keeps the upper nibble of d_pc+4.
    d_pc = 32'hF000_0000; npc_op = 3'd2; imm26 = 26'h0000100; b_j = 1'b0;
    #1;
    chk("j_npc", npc, 32'hF000_0400);
    chk("j_link", d_link, 32'hF000_0008);
    chk("j_redirect", {31'd0, redirect}, 32'd1);
    stall = 1'b1;
    #1;
    chk("j_link_stall", d_link, 32'hF000_0008);
    chk("j_redirect_stall", {31'd0, redirect}, 32'd1);
    stall = 1'b0;
    step();
    chk("j_f_pc", f_pc, 32'hF000_0400);
    chk("j_cnt", {16'd0, taken_cnt}, 32'd2);

    // jr during a 2-edge stall; rs_d is forwarded late and must be honoured.
    npc_op = 3'd3; rs_d = 32'h0000_5000; stall = 1'b1;
    #1;
    chk("jr_npc_early", npc, 32'h0000_5000);
    step();
    chk("jr_hold1_f_pc", f_pc, 32'hF000_0400);
    chk("jr_hold1_cnt", {16'd0, taken_cnt}, 32'd2);
    rs_d = 32'h0000_3002;
    step();
    chk("jr_hold2_f_pc", f_pc, 32'hF000_0400);
    chk("jr_hold2_cnt", {16'd0, taken_cnt}, 32'd2);
    chk("jr_hold2_adel", {31'd0, adel_f}, 32'd0);
    stall = 1'b0;
    step();
    chk("jr_f_pc", f_pc, 32'h0000_3002);
    chk("jr_adel", {31'd0, adel_f}, 32'd1);
    chk("jr_cnt", {16'd0, taken_cnt}, 32'd3);
    npc_op = 3'd0;
    step();
    chk("adel_sticky_f_pc", f_pc, 32'h0000_3006);
    chk("adel_sticky", {31'd0, adel_f}, 32'd1);
    chk("adel_sticky_cnt", {16'd0, taken_cnt}, 32'd3);

    // Async reset mid-cycle, then held through an edge with a jr pending.
    npc_op = 3'd3; rs_d = 32'h0000_7000;
    reset = 1'b1;
    #1;
    chk("arst_f_pc", f_pc, 32'h0000_3000);
    chk("arst_adel", {31'd0, adel_f}, 32'd0);
    chk("arst_cnt", {16'd0, taken_cnt}, 32'd0);
    step();
    chk("rst_dom_f_pc", f_pc, 32'h0000_3000);
    chk("rst_dom_cnt", {16'd0, taken_cnt}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Wrap of the fetch PC at the top of the address space.
    rs_d = 32'hFFFF_FFFC;
    step();
    chk("wrap_pre_f_pc", f_pc, 32'hFFFF_FFFC);
    chk("wrap_pre_cnt", {16'd0, taken_cnt}, 32'd1);
    npc_op = 3'd0;
    #1;
    chk("wrap_npc", npc, 32'h0000_0000);
    step();
    chk("wrap_f_pc", f_pc, 32'h0000_0000);
    chk("wrap_adel", {31'd0, adel_f}, 32'd0);
    chk("wrap_cnt", {16'd0, taken_cnt}, 32'd1);

    // Counter saturation: fresh reset, then a continuous stream of jumps.
    reset = 1'b1;
    #1;
    @(negedge clk);
    reset = 1'b0;
    d_pc = 32'h0000_0000; npc_op = 3'd2; imm26 = 26'h0000040;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", {16'd0, taken_cnt}, 32'h0000_FFFE);
    step();
    chk("sat_ffff", {16'd0, taken_cnt}, 32'h0000_FFFF);
    step();
    chk("sat_hold", {16'd0, taken_cnt}, 32'h0000_FFFF);
    chk("sat_f_pc", f_pc, 32'h0000_0100);

    // Async reset between edges clears everything before the next edge.
    #2 reset = 1'b1;
    #1;
    chk("sat_rst_f_pc", f_pc, 32'h0000_3000);
    chk("sat_rst_adel", {31'd0, adel_f}, 32'd0);
    chk("sat_rst_cnt", {16'd0, taken_cnt}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    npc_op = 3'd0;
    step();
    chk("post_rst_f_pc", f_pc, 32'h0000_3004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
